m31_full_round_sched: RTL and testbench
=======================================

M31_FULL_ROUND_SCHED -- requirements
Module: m31_full_round_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 16: state elements per permutation.
REQ-002 SHALL have parameter ROUNDS, default 4: consecutive full rounds per call.
REQ-003 SHALL have parameter RND_LAT, default 13: the external full-round datapath's latency in cycles, from input sample to registered output.
REQ-004 SHALL have parameter ROUND_BASE, default 0: index of the first round constant row used.
REQ-005 SHALL have port clk, input, 1: clock.
REQ-006 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port in_valid, input, 1: upstream state valid.
REQ-008 SHALL have port in_ready, output, 1: block can accept a state.
REQ-009 SHALL have port in_state, input, WIDTH x m31_t: canonical input state.
REQ-010 SHALL have port out_valid, output, 1: result state valid.
REQ-011 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-012 SHALL have port out_state, output, WIDTH x m31_t: state after ROUNDS full rounds.
REQ-013 SHALL have port rnd_state_o, output, WIDTH x m31_t: state driven to the full-round datapath.
REQ-014 SHALL have port rnd_const_o, output, WIDTH x m31_t: round constants driven to the datapath.
REQ-015 SHALL have port rnd_issue_o, output, 1: marks the cycle in which rnd_state_o and rnd_const_o are meaningful.
REQ-016 SHALL have port rnd_state_i, input, WIDTH x m31_t: registered result from the datapath.

Function
REQ-017 SHALL implement FSM IDLE, ISSUE, WAIT, DONE.
- Round counter rnd: 0..ROUNDS-1.
- Latency counter lat: 0..RND_LAT-1.
- One WIDTH-element state register st.
REQ-018 IDLE: in_ready=1; on in_valid, in_state->st, rnd=0, go to ISSUE. All other states: in_ready=0, in_valid ignored.
REQ-019 ISSUE lasts exactly 1 cycle.
- rnd_issue_o=1, rnd_state_o=st, rnd_const_o=rc_row[ROUND_BASE+rnd].
- Load lat=0, go to WAIT.
REQ-020 Outside ISSUE: rnd_issue_o=0, rnd_state_o=0, rnd_const_o=0.
REQ-021 WAIT: lat increments each cycle.
- At lat==RND_LAT-1: rnd_state_i->st.
- If rnd==ROUNDS-1, go to DONE; else rnd+1 and go to ISSUE.
- Each round occupies RND_LAT+1 cycles.
REQ-022 DONE: out_valid=1, out_state=st, held stable while out_ready=0; on out_ready, go to IDLE.
REQ-023 out_state SHALL be 0 whenever out_valid=0.
REQ-024 A DONE->IDLE handoff SHALL insert exactly one idle cycle before the next accept (no accept in DONE even if in_valid=1).
REQ-025 Latency, counting the accept cycle as 0: out_valid first high in cycle ROUNDS*(RND_LAT+1)+1, which is 57 at defaults.
REQ-026 The block SHALL perform no field arithmetic. Constants are passed unmodified; constant row index = ROUND_BASE+rnd, with no wrap.

Reset
REQ-027 rst_n=0 at a clock edge SHALL force:
- state IDLE, rnd=0, lat=0, st=0;
- in_ready=1 from the first cycle after reset, all other outputs 0.
REQ-028 Reset mid-operation SHALL abort the permutation with no output produced. Datapath results still in flight SHALL be ignored.

Configuration
REQ-029 With M31_SCHED_PERF_EN defined, the block SHALL add output perm_count_o, 32 bits.
- Counts DONE->IDLE handoffs; wraps from 0xFFFFFFFF to 0; reset to 0.
- Without the macro, the port and counter SHALL be absent.

Structure
REQ-030 m31_pkg SHALL hold m31_t, M31_P (2^31-1), and the round-constant table with its row count.
REQ-031 Constant lookup SHALL be one sub-module, m31_rc_rom: combinational, input row index, output WIDTH constants.

Verification
REQ-032 Reset, then in_state all 1, with a stub datapath that adds 1 per element after 13 cycles -> out_valid in cycle 57, out_state all 5.
REQ-033 out_ready held 0 for 20 cycles in DONE -> out_valid and out_state stable; in_ready=0 throughout.
REQ-034 in_valid held 1 continuously -> accepts spaced exactly 58 cycles apart (57 + 1 idle cycle); rnd_issue_o pulses 4 times per permutation.
REQ-035 rnd_const_o during the four ISSUE cycles equals m31_rc_rom rows ROUND_BASE..ROUND_BASE+3, in order.
REQ-036 rst_n=0 in cycle 30 of a permutation -> all outputs 0 next cycle, in_ready=1; the following permutation completes correctly.
REQ-037 With M31_SCHED_PERF_EN defined, 3 completed permutations -> perm_count_o=3; a reset -> perm_count_o=0.

Source files
------------

// File: rtl/m31_pkg.sv
// Shared types and round-constant table for the M31 full-round scheduler.
package m31_pkg;

  typedef logic [30:0] m31_t;

  localparam m31_t M31_P = 31'h7FFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } sched_state_e;

  localparam int RC_ROWS  = 8;
  localparam int RC_COLS  = 16;
  localparam int RC_IDX_W = $clog2(RC_ROWS);

  // Canonical constants (all below M31_P); one row per full round.
  localparam m31_t RC_TABLE [RC_ROWS][RC_COLS] = '{
    '{31'h0a1b2c3d, 31'h1c2d3e4f, 31'h2e3f4051, 31'h30415263, 31'h42536475, 31'h54657687, 31'h66778899, 31'h78899aab,
      31'h0badcafe, 31'h1eedface, 31'h2abcdef1, 31'h3c0ffee5, 31'h4deadbee, 31'h5a5a5a5a, 31'h6b6b6b6b, 31'h7c7c7c7c},
    '{31'h13579bdf, 31'h2468ace0, 31'h3579bdf1, 31'h468ace02, 31'h579bdf13, 31'h68ace024, 31'h79bdf135, 31'h0ace0246,
      31'h1bdf1357, 31'h2ce02468, 31'h3df13579, 31'h4e02468a, 31'h5f13579b, 31'h602468ac, 31'h713579bd, 31'h02468ace},
    '{31'h1234abcd, 31'h2345bcde, 31'h3456cdef, 31'h4567def0, 31'h5678ef01, 31'h6789f012, 31'h789a0123, 31'h09ab1234,
      31'h1abc2345, 31'h2bcd3456, 31'h3cde4567, 31'h4def5678, 31'h5ef06789, 31'h6f01789a, 31'h701289ab, 31'h01239abc},
    '{31'h7edcba98, 31'h6dcba987, 31'h5cba9876, 31'h4ba98765, 31'h3a987654, 31'h29876543, 31'h18765432, 31'h07654321,
      31'h76543210, 31'h6543210f, 31'h543210fe, 31'h43210fed, 31'h3210fedc, 31'h210fedcb, 31'h10fedcba, 31'h0fedcba9},
    '{31'h0f0f0f0f, 31'h1e1e1e1e, 31'h2d2d2d2d, 31'h3c3c3c3c, 31'h4b4b4b4b, 31'h5a5a5a5a, 31'h69696969, 31'h78787878,
      31'h07070707, 31'h16161616, 31'h25252525, 31'h34343434, 31'h43434343, 31'h52525252, 31'h61616161, 31'h70707070},
    '{31'h3141592f, 31'h26535897, 31'h3238462f, 31'h64338327, 31'h15028841, 31'h71693993, 31'h75105820, 31'h09749445,
      31'h23078164, 31'h06286208, 31'h69986280, 31'h34825342, 31'h11706798, 31'h21480865, 31'h13282306, 31'h64709384},
    '{31'h27182818, 31'h28459045, 31'h23536028, 31'h74713526, 31'h62497757, 31'h24709369, 31'h59957496, 31'h69676277,
      31'h24076630, 31'h35354759, 31'h45713821, 31'h78525166, 31'h42746639, 31'h19320030, 31'h59921817, 31'h41354225},
    '{31'h14142135, 31'h62373095, 31'h04880168, 31'h72420969, 31'h48073566, 31'h33797807, 31'h75305346, 31'h05021345,
      31'h17320508, 31'h07568877, 31'h29352744, 31'h63427594, 31'h22360679, 31'h77499789, 31'h69640917, 31'h36619921}
  };

  function automatic logic rc_row_valid(input logic [31:0] row);
    return row < 32'(RC_ROWS);
  endfunction

endpackage

// File: rtl/m31_rc_rom.sv
// Combinational round-constant lookup: one table row, WIDTH elements wide.
// Rows past the table and columns past RC_COLS read as zero (no wrap).
module m31_rc_rom
  import m31_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [31:0]      i_row,
  output m31_t [WIDTH-1:0] o_rc
);

  logic                w_row_ok;
  logic [RC_IDX_W-1:0] w_idx;

  assign w_row_ok = rc_row_valid(i_row);
  assign w_idx    = i_row[RC_IDX_W-1:0];

  for (genvar g = 0; g < WIDTH; g++) begin : g_col
    if (g < RC_COLS) begin : g_tab
      assign o_rc[g] = w_row_ok ? RC_TABLE[w_idx][g] : '0;
    end else begin : g_pad
      assign o_rc[g] = '0;
    end
  end

endmodule

// File: rtl/m31_full_round_sched.sv
// Sequences ROUNDS full rounds of an M31 permutation through an external datapath.
// Optional M31_SCHED_PERF_EN adds perm_count_o, a wrapping count of delivered results.
module m31_full_round_sched
  import m31_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int ROUNDS     = 4,
  parameter int RND_LAT    = 13,
  parameter int ROUND_BASE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  m31_t [WIDTH-1:0] in_state,
  output logic             out_valid,
  input  logic             out_ready,
  output m31_t [WIDTH-1:0] out_state,
  output m31_t [WIDTH-1:0] rnd_state_o,
  output m31_t [WIDTH-1:0] rnd_const_o,
  output logic             rnd_issue_o,
  input  m31_t [WIDTH-1:0] rnd_state_i
`ifdef M31_SCHED_PERF_EN
  ,
  output logic [31:0]      perm_count_o
`endif
);

  localparam int RND_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam int LAT_W = (RND_LAT > 1) ? $clog2(RND_LAT) : 1;
  localparam logic [RND_W-1:0] RND_LAST = RND_W'(ROUNDS - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RND_LAT - 1);

  sched_state_e     r_state;
  sched_state_e     w_state_nxt;
  logic [RND_W-1:0] r_rnd;
  logic [LAT_W-1:0] r_lat;
  m31_t [WIDTH-1:0] r_st;

  logic             w_issue;
  logic             w_done;
  logic             w_lat_last;
  logic [31:0]      w_row;
  m31_t [WIDTH-1:0] w_rc;

  assign w_issue    = (r_state == S_ISSUE);
  assign w_done     = (r_state == S_DONE);
  assign w_lat_last = (r_lat == LAT_LAST);
  assign w_row      = 32'(ROUND_BASE) + 32'(r_rnd);

  m31_rc_rom #(
    .WIDTH (WIDTH)
  ) u_rc_rom (
    .i_row (w_row),
    .o_rc  (w_rc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_lat_last) w_state_nxt = (r_rnd == RND_LAST) ? S_DONE : S_ISSUE;
      end
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The datapath result is captured on the last wait cycle; earlier or stale
  // values on rnd_state_i are never looked at.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rnd <= '0;
      r_lat <= '0;
      r_st  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_st  <= in_state;
            r_rnd <= '0;
          end
        end
        S_ISSUE: r_lat <= '0;
        S_WAIT: begin
          r_lat <= r_lat + 1'b1;
          if (w_lat_last) begin
            r_st <= rnd_state_i;
            if (r_rnd != RND_LAST) r_rnd <= r_rnd + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = w_done;
  assign out_state   = w_done ? r_st : '0;
  assign rnd_issue_o = w_issue;
  assign rnd_state_o = w_issue ? r_st : '0;
  assign rnd_const_o = w_issue ? w_rc : '0;

`ifdef M31_SCHED_PERF_EN
  logic [31:0] r_perm_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perm_cnt <= '0;
    end else if (w_done && out_ready) begin
      r_perm_cnt <= r_perm_cnt + 32'd1;
    end
  end

  assign perm_count_o = r_perm_cnt;
`endif

endmodule

// File: tb/tb_m31_full_round_sched.sv
// Bench for m31_full_round_sched with a stub datapath adding 1 per element after RND_LAT cycles.
module tb_m31_full_round_sched;
  import m31_pkg::*;

  localparam int W       = 16;
  localparam int NR      = 4;
  localparam int RL      = 13;
  localparam int RB      = 1;
  localparam int LAT_EXP = NR * (RL + 1) + 1;

  typedef m31_t [W-1:0] vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  vec_t in_state = '0;
  logic in_ready, out_valid, rnd_issue_o;
  vec_t out_state, rnd_state_o, rnd_const_o, rnd_state_i;
`ifdef M31_SCHED_PERF_EN
  logic [31:0] perm_count_o;
`endif

  m31_full_round_sched #(
    .WIDTH(W), .ROUNDS(NR), .RND_LAT(RL), .ROUND_BASE(RB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .rnd_state_o(rnd_state_o), .rnd_const_o(rnd_const_o),
    .rnd_issue_o(rnd_issue_o), .rnd_state_i(rnd_state_i)
`ifdef M31_SCHED_PERF_EN
    , .perm_count_o(perm_count_o)
`endif
  );

  always #5 clk = ~clk;

  // Stub datapath: samples the driven state, returns it +1 per element RL cycles later.
  vec_t pipe [RL];
  always @(posedge clk) begin
    for (int e = 0; e < W; e++) pipe[0][e] <= rnd_state_o[e] + 31'd1;
    for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
  end
  assign rnd_state_i = pipe[RL-1];

  int checks = 0;
  int errors = 0;

  vec_t cap_const [8];
  vec_t cap_state [8];
  vec_t cap_out;
  int   cap_n;
  int   cap_lat;
  bit   cap_rdy_bad;

  function automatic vec_t rand_vec();
    vec_t v;
    for (int e = 0; e < W; e++) v[e] = m31_t'($urandom % 32'h7FFF_FFFB);
    return v;
  endfunction

  function automatic vec_t add_all(input vec_t v, input int k);
    vec_t r;
    for (int e = 0; e < W; e++) r[e] = v[e] + m31_t'(k);
    return r;
  endfunction

  function automatic vec_t rc_exp(input int row);
    vec_t r;
    for (int e = 0; e < W; e++) r[e] = RC_TABLE[row][e];
    return r;
  endfunction

  // Runs one permutation; returns at the negedge of the first out_valid cycle.
  task automatic do_perm(input vec_t v);
    int n;
    cap_n = 0; cap_lat = -1; cap_rdy_bad = 1'b0; cap_out = '0;
    in_state = v; in_valid = 1'b1;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_state = rand_vec();
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (in_ready) cap_rdy_bad = 1'b1;
      if (rnd_issue_o) begin
        if (cap_n < 8) begin
          cap_const[cap_n] = rnd_const_o;
          cap_state[cap_n] = rnd_state_o;
        end
        cap_n++;
      end
      if (out_valid) begin
        cap_lat = c;
        cap_out = out_state;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_state !== '0) begin errors++; $display("FAIL reset_out_state got %h want 0", out_state); end
    checks++; if (rnd_issue_o !== 1'b0) begin errors++; $display("FAIL reset_issue got %b want 0", rnd_issue_o); end
    checks++; if (rnd_state_o !== '0 || rnd_const_o !== '0) begin
      errors++; $display("FAIL reset_rnd_bus got %h / %h want 0", rnd_state_o, rnd_const_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    vec_t v;
    for (int e = 0; e < W; e++) v[e] = 31'd1;
    out_ready = 1'b1;
    do_perm(v);
    checks++; if (cap_lat != LAT_EXP) begin errors++; $display("FAIL basic_latency got %0d want %0d", cap_lat, LAT_EXP); end
    checks++; if (cap_out !== add_all(v, NR)) begin errors++; $display("FAIL basic_out got %h want %h", cap_out, add_all(v, NR)); end
    checks++; if (cap_n != NR) begin errors++; $display("FAIL basic_issue_count got %0d want %0d", cap_n, NR); end
    for (int k = 0; k < NR && k < cap_n; k++) begin
      checks++; if (cap_const[k] !== rc_exp(RB + k)) begin
        errors++; $display("FAIL basic_const%0d got %h want %h", k, cap_const[k], rc_exp(RB + k));
      end
      checks++; if (cap_state[k] !== add_all(v, k)) begin
        errors++; $display("FAIL basic_issue_state%0d got %h want %h", k, cap_state[k], add_all(v, k));
      end
    end
    checks++; if (cap_rdy_bad) begin errors++; $display("FAIL basic_in_ready_busy got 1 want 0"); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || out_state !== '0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL basic_after_handoff got vld=%b rdy=%b st=%h want vld=0 rdy=1 st=0", out_valid, in_ready, out_state);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    vec_t v;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      v = rand_vec();
      do_perm(v);
      checks++; if (cap_lat != LAT_EXP) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", i, cap_lat, LAT_EXP); end
      checks++; if (cap_out !== add_all(v, NR)) begin errors++; $display("FAIL rand%0d_out got %h want %h", i, cap_out, add_all(v, NR)); end
      checks++; if (cap_n != NR) begin errors++; $display("FAIL rand%0d_issues got %0d want %0d", i, cap_n, NR); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    vec_t v, ex;
    v = rand_vec();
    ex = add_all(v, NR);
    out_ready = 1'b0;
    do_perm(v);
    checks++; if (cap_lat != LAT_EXP) begin errors++; $display("FAIL stall_latency got %0d want %0d", cap_lat, LAT_EXP); end
    checks++; if (cap_out !== ex) begin errors++; $display("FAIL stall_out got %h want %h", cap_out, ex); end
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_state = rand_vec();
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_state !== ex || in_ready !== 1'b0) begin
        errors++; $display("FAIL stall_hold%0d got vld=%b rdy=%b st=%h want vld=1 rdy=0 st=%h", c, out_valid, in_ready, out_state, ex);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_release got %b want 1", out_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL stall_idle got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int   acc_cyc [$];
    vec_t exp_q [$];
    int   issues;
    int   outs;
    bit   acc;
    issues = 0; outs = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_state = rand_vec();
    for (int c = 0; c < 3 * (LAT_EXP + 1); c++) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) begin
        acc_cyc.push_back(c);
        exp_q.push_back(add_all(in_state, NR));
      end
      if (rnd_issue_o) issues++;
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected_out cycle %0d got out_valid=1 want 0", c);
        end else if (out_state !== exp_q[0] || c != acc_cyc[outs] + LAT_EXP) begin
          errors++; $display("FAIL b2b_out%0d got cyc=%0d st=%h want cyc=%0d st=%h", outs, c, out_state, acc_cyc[outs] + LAT_EXP, exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        outs++;
      end
      @(posedge clk); #1;
      if (acc) in_state = rand_vec();
    end
    in_valid = 1'b0;
    checks++; if (acc_cyc.size() != 3) begin errors++; $display("FAIL b2b_accepts got %0d want 3", acc_cyc.size()); end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      checks++; if (acc_cyc[i] - acc_cyc[i-1] != LAT_EXP + 1) begin
        errors++; $display("FAIL b2b_spacing%0d got %0d want %0d", i, acc_cyc[i] - acc_cyc[i-1], LAT_EXP + 1);
      end
    end
    checks++; if (issues != 3 * NR) begin errors++; $display("FAIL b2b_issues got %0d want %0d", issues, 3 * NR); end
    checks++; if (outs != 3) begin errors++; $display("FAIL b2b_outputs got %0d want 3", outs); end
  endtask

  task automatic test_reset_mid();
    vec_t v;
    bit   bad;
    v = rand_vec();
    out_ready = 1'b1;
    in_state = v; in_valid = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_accept got in_ready=%b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (29) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_state !== '0 || rnd_issue_o !== 1'b0 ||
                  rnd_state_o !== '0 || rnd_const_o !== '0) begin
      errors++; $display("FAIL rmid_outputs got rdy=%b vld=%b iss=%b st=%h want rdy=1 vld=0 iss=0 st=0",
                         in_ready, out_valid, rnd_issue_o, out_state);
    end
    bad = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (out_valid !== 1'b0 || rnd_issue_o !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL rmid_aborted got activity=1 want 0"); end
    @(posedge clk); #1;
    v = rand_vec();
    do_perm(v);
    checks++; if (cap_lat != LAT_EXP) begin errors++; $display("FAIL rmid_next_latency got %0d want %0d", cap_lat, LAT_EXP); end
    checks++; if (cap_out !== add_all(v, NR)) begin errors++; $display("FAIL rmid_next_out got %h want %h", cap_out, add_all(v, NR)); end
    @(posedge clk); #1;
  endtask

`ifdef M31_SCHED_PERF_EN
  task automatic test_perf();
    apply_reset();
    @(negedge clk);
    checks++; if (perm_count_o !== 32'd0) begin errors++; $display("FAIL perf_reset0 got %0d want 0", perm_count_o); end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      do_perm(rand_vec());
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if (perm_count_o !== 32'd3) begin errors++; $display("FAIL perf_count got %0d want 3", perm_count_o); end
    apply_reset();
    @(negedge clk);
    checks++; if (perm_count_o !== 32'd0) begin errors++; $display("FAIL perf_reset1 got %0d want 0", perm_count_o); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_stall();
    test_back_to_back();
    test_reset_mid();
`ifdef M31_SCHED_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
